// File: rtl/arb_pkg.sv
// Shared types and constants for the rr_arb_enc round-robin arbiter.
package arb_pkg;

  localparam int unsigned N        = 8;
  localparam int unsigned IDXW     = 3;
  localparam int unsigned TO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set request scanning ptr, ptr+1, ... with wrap.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            any
);

  logic [IDXW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Natural IDXW-bit wrap provides the 7 -> 0 rollover.
      idx = ptr + IDXW'(i);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_enc.sv
// Eight-input round-robin arbiter with registered 3-bit grant index for a 3-to-8 decoder.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.
module rr_arb_enc #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            busy,
  output logic            timeout
);
  import arb_pkg::*;

  if (N != 8 || IDXW != $clog2(N) || MAX_HOLD < 1 || MAX_HOLD > (1 << TO_CNT_W)) begin : g_bad_cfg
    $error("rr_arb_enc: unsupported N/IDXW/MAX_HOLD combination");
  end

  state_t          state, state_next;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] winner;
  logic            any;
  logic            owner_rel;
  logic            force_rel;
  logic            rel_go;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign owner_rel = done || !req[gnt_idx];
  assign rel_go    = owner_rel || force_rel;
  assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] hold_cnt;

  assign force_rel = (hold_cnt == TO_CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE && any) begin
        hold_cnt <= '0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
        // A genuine release in the same cycle wins over the forced one.
        if (force_rel && !owner_rel) timeout <= 1'b1;
      end
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any) state_next = GRANT;
      GRANT:   if (rel_go) state_next = REL;
      REL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && any) begin
        gnt_idx   <= winner;
        gnt_valid <= 1'b1;
      end else if (state == GRANT && rel_go) begin
        gnt_valid <= 1'b0;
        ptr       <= gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_enc.sv
// Directed self-checking bench for rr_arb_enc; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_rr_arb_enc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arb_enc #(.N(8), .IDXW(3), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({gnt_idx, gnt_valid, busy, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got idx=%0d valid=%b busy=%b timeout=%b, want all 0",
               gnt_idx, gnt_valid, busy, timeout);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_no_req: got valid=%b busy=%b, want 0 0", gnt_valid, busy);
    end
  endtask

  task automatic test_single();
    req = 8'b0000_0100;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got valid=%b idx=%0d busy=%b, want 1 2 1", gnt_valid, gnt_idx, busy);
    end
    req = 8'b1111_0100;
    tick();
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL single_hold: got valid=%b idx=%0d, want 1 2", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b1 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL single_release: got valid=%b busy=%b idx=%0d, want 0 1 2", gnt_valid, busy, gnt_idx);
    end
    done = 1'b0;
    req  = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_rel_to_idle: got busy=%b, want 0", busy);
    end
    req = 8'b0000_1100;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL single_ptr_advance: got valid=%b idx=%0d, want 1 3", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL rr_first: got valid=%b idx=%0d, want 1 0", gnt_valid, gnt_idx);
    end
    for (int k = 1; k <= 8; k++) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_rel_%0d: got valid=%b busy=%b, want 0 1", k, gnt_valid, busy);
      end
      tick();
      checks++;
      if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_%0d: got valid=%b busy=%b, want 0 0", k, gnt_valid, busy);
      end
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'(k % 8)) begin
        errors++;
        $display("FAIL rr_grant_%0d: got valid=%b idx=%0d, want 1 %0d", k, gnt_valid, gnt_idx, k % 8);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b0010_0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
    req = 8'b0000_0011;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL wrap_to_0: got valid=%b idx=%0d, want 1 0", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd1) begin
      errors++;
      $display("FAIL wrap_next_1: got valid=%b idx=%0d, want 1 1", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  task automatic test_req_drop();
    req = 8'b0000_1000;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL drop_grant: got valid=%b idx=%0d, want 1 3", gnt_valid, gnt_idx);
    end
    req = '0;
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_release: got valid=%b busy=%b, want 0 1", gnt_valid, busy);
    end
    tick();
    done = 1'b1;
    tick();
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL idle_done_ignored: got valid=%b busy=%b idx=%0d, want 0 0 3", gnt_valid, busy, gnt_idx);
    end
    done = 1'b0;
    req  = 8'b0001_1000;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4) begin
      errors++;
      $display("FAIL drop_ptr_advance: got valid=%b idx=%0d, want 1 4", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    req  = '0;
    tick();
    done = 1'b0;
    tick();
    req = 8'b0011_0000;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL simul_single_release: got valid=%b idx=%0d, want 1 5", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'b0010_0000;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL midrst_grant: got valid=%b idx=%0d, want 1 5", gnt_valid, gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b busy=%b idx=%0d, want 0 0 0", gnt_valid, busy, gnt_idx);
    end
    #3;
    rst_n = 1'b1;
    req   = 8'hA0;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL midrst_ptr0: got valid=%b idx=%0d, want 1 5", gnt_valid, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'b0000_1100;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold_%0d: got valid=%b timeout=%b, want 1 0", c, gnt_valid, timeout);
      end
    end
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: got valid=%b timeout=%b, want 0 1", gnt_valid, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width: got timeout=%b, want 0", timeout);
    end
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL to_next_winner: got valid=%b idx=%0d, want 1 3", gnt_valid, gnt_idx);
    end
`else
    for (int c = 0; c < 40; c++) tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_hold: got valid=%b idx=%0d timeout=%b, want 1 2 0", gnt_valid, gnt_idx, timeout);
    end
`endif
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
